// File: rtl/des_pkg.sv
// Shared DES round constants: E expansion and P permutation tables, controller
// state encoding, and the pure bit-permutation helpers used by the round datapath.
package des_pkg;

  localparam int ROUNDS_DEF = 16;

  // Tables use DES numbering: bit 1 is the MSB of the source word.
  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  function automatic logic [47:0] des_expand(input logic [31:0] r);
    logic [47:0] e;
    e = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TABLE[i]];
    return e;
  endfunction

  function automatic logic [31:0] des_pbox(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TABLE[i]];
    return p;
  endfunction

endpackage

// File: rtl/des_round_ctrl.sv
// Sequences the DES Feistel rounds around an external S-box compression unit,
// one subkey fetch and one scomp transaction per round.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS        = ROUNDS_DEF,
  parameter int SCOMP_TIMEOUT = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] blk_in,
  input  logic        blk_in_valid,
  input  logic        decrypt_in,
  output logic        blk_in_ready,
  output logic [3:0]  subkey_idx_out,
  input  logic [47:0] subkey_in,
  output logic [47:0] s_data_out,
  output logic        s_data_out_valid,
  input  logic [31:0] scomp_in,
  input  logic        scomp_in_valid,
  output logic [63:0] blk_out,
  output logic        blk_out_valid,
  input  logic        blk_out_ready,
  output logic        err_out
);

  localparam int TW = $clog2(SCOMP_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [31:0]     l_q, l_d, r_q, r_d;
  logic            mode_q, mode_d;
  logic [3:0]      round_q, round_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic [47:0]     sdata_q, sdata_d, issue_data;
  logic [3:0]      issue_idx;
  logic            timeout;

  assign issue_idx  = mode_q ? (4'(ROUNDS - 1) - round_q) : round_q;
  assign issue_data = des_expand(r_q) ^ subkey_in;
  assign timer_inc  = timer_q + 1'b1;
  // A response arriving on the last allowed cycle still completes the round.
  assign timeout    = (state_q == WAIT) && !scomp_in_valid &&
                      (timer_inc == TW'(SCOMP_TIMEOUT));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
      round_q <= '0;
      timer_q <= '0;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      timer_q <= timer_d;
      sdata_q <= sdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    mode_d  = mode_q;
    round_d = round_q;
    timer_d = timer_q;
    sdata_d = sdata_q;
    unique case (state_q)
      IDLE: begin
        if (blk_in_valid) begin
          l_d     = blk_in[63:32];
          r_d     = blk_in[31:0];
          mode_d  = decrypt_in;
          round_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sdata_d = issue_data;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_inc;
        if (scomp_in_valid) begin
          l_d = r_q;
          r_d = l_q ^ des_pbox(scomp_in);
          if (round_q == 4'(ROUNDS - 1)) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = ISSUE;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (blk_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_in_ready     = (state_q == IDLE);
    s_data_out_valid = (state_q == ISSUE);
    subkey_idx_out   = (state_q == ISSUE) ? issue_idx : 4'd0;
    s_data_out       = (state_q == ISSUE) ? issue_data : sdata_q;
    // The last round's swap is undone here by presenting R16 in the upper half.
    blk_out          = {r_q, l_q};
    blk_out_valid    = (state_q == DONE);
    err_out          = timeout;
  end

endmodule
